chip8_draw_controller: RTL and testbench

- Sequences all writes into the Chip-8 framebuffer. Executes DXYN sprite draws and 00E0 screen clears issued by the CPU core.
- A draw is a per-pixel read-modify-write: fetch sprite bytes from main memory, XOR them into the framebuffer, report collision for VF.
- Sits between the CPU instruction FSM, the main memory read port, and a pixel-addressed framebuffer port.

---
 rtl/chip8_draw_pkg.sv | 23 ++
 rtl/chip8_pixel_addr_gen.sv | 63 ++++++
 rtl/chip8_draw_controller.sv | 146 ++++++++++++++
 tb/tb_chip8_draw_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_draw_pkg.sv
// Shared types and screen geometry for the Chip-8 framebuffer write path.
// Pure declarations, no logic and no latency.
// Screen dimensions must stay powers of two so wrapping is plain truncation.
package chip8_draw_pkg;

  localparam int SCREEN_W  = 64;
  localparam int SCREEN_H  = 32;
  localparam int FB_PIXELS = SCREEN_W * SCREEN_H;
  localparam int X_W       = $clog2(SCREEN_W);
  localparam int Y_W       = $clog2(SCREEN_H);
  localparam int CNT_W     = $clog2(FB_PIXELS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PIX_RD,
    PIX_WR,
    CLEAR,
    DONE
  } draw_state_t;

endpackage

// File: rtl/chip8_pixel_addr_gen.sv
// Row/column/clear counters and wrapped framebuffer pixel address.
// Counters update one cycle after a step/load; fb_x/fb_y are combinational.
// No backpressure: the controller FSM decides every step.
module chip8_pixel_addr_gen
  import chip8_draw_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [7:0]     x_in,
  input  logic [7:0]     y_in,
  input  logic           col_clr,
  input  logic           col_step,
  input  logic           row_step,
  input  logic           clr_step,
  input  logic           clear_mode,
  output logic [X_W-1:0] fb_x,
  output logic [Y_W-1:0] fb_y,
  output logic [3:0]     row,
  output logic [2:0]     col,
  output logic           clr_last
);

  logic [X_W-1:0]   x0;
  logic [Y_W-1:0]   y0;
  logic [CNT_W-1:0] cnt;

  // Origin latch and counters; load restarts everything for a new command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0  <= '0;
      y0  <= '0;
      row <= '0;
      col <= '0;
      cnt <= '0;
    end else if (load) begin
      // Truncation is the modulo: screen dimensions are powers of two.
      x0  <= X_W'(x_in);
      y0  <= Y_W'(y_in);
      row <= '0;
      col <= '0;
      cnt <= '0;
    end else begin
      if (col_clr)       col <= '0;
      else if (col_step) col <= col + 3'd1;
      if (row_step)      row <= row + 4'd1;
      if (clr_step)      cnt <= cnt + 1'b1;
    end
  end

  // Raster scan while clearing, otherwise sprite origin plus offsets with wrap.
  always_comb begin
    clr_last = (cnt == CNT_W'(FB_PIXELS - 1));
    if (clear_mode) begin
      fb_x = cnt[X_W-1:0];
      fb_y = cnt[CNT_W-1:X_W];
    end else begin
      fb_x = x0 + X_W'(col);
      fb_y = y0 + Y_W'(row);
    end
  end

endmodule

// File: rtl/chip8_draw_controller.sv
// Executes DXYN sprite draws (RMW XOR with collision) and 00E0 clears.
// Draw takes 18*N+1 cycles start-to-done (1 for N=0); clear takes 2049.
// Starts are accepted only in IDLE; requests while busy are dropped.
module chip8_draw_controller
  import chip8_draw_pkg::*;
#(
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  draw_start,
  input  logic                  clear_start,
  input  logic [7:0]            draw_x,
  input  logic [7:0]            draw_y,
  input  logic [3:0]            draw_n,
  input  logic [MEM_ADDR_W-1:0] draw_i,
  output logic                  busy,
  output logic                  done,
  output logic                  collision,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic [X_W-1:0]        fb_x,
  output logic [Y_W-1:0]        fb_y,
  input  logic                  fb_rbit,
  output logic                  fb_wbit,
  output logic                  fb_we
);

  draw_state_t           state, state_nxt;
  logic [3:0]            n_q;
  logic [MEM_ADDR_W-1:0] i_q;
  logic [7:0]            sprite;
  logic [3:0]            row;
  logic [2:0]            col;
  logic                  clr_last;
  logic                  start_acc;
  logic                  sprite_bit;
  logic                  last_row;
  logic                  col_clr, col_step, row_step, clr_step;

  assign start_acc  = (state == IDLE) && (clear_start || draw_start);
  assign sprite_bit = sprite[3'd7 - col];
  assign last_row   = (row == n_q - 4'd1);

  chip8_pixel_addr_gen u_addr (
    .clk        (clk),
    .reset      (reset),
    .load       (start_acc),
    .x_in       (draw_x),
    .y_in       (draw_y),
    .col_clr    (col_clr),
    .col_step   (col_step),
    .row_step   (row_step),
    .clr_step   (clr_step),
    .clear_mode (state == CLEAR),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .row        (row),
    .col        (col),
    .clr_last   (clr_last)
  );

  // State register; reset aborts any command without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command latches, sprite byte capture and sticky collision flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q       <= '0;
      i_q       <= '0;
      sprite    <= '0;
      collision <= 1'b0;
    end else begin
      if (start_acc) begin
        n_q       <= draw_n;
        i_q       <= draw_i;
        collision <= 1'b0;
      end
      if (state == LATCH) sprite <= mem_rdata;
      if (state == PIX_RD && sprite_bit && fb_rbit) collision <= 1'b1;
    end
  end

  // Next-state, counter steps and memory/framebuffer strobes.
  always_comb begin
    state_nxt = state;
    col_clr   = 1'b0;
    col_step  = 1'b0;
    row_step  = 1'b0;
    clr_step  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    fb_we     = 1'b0;
    fb_wbit   = 1'b0;
    case (state)
      IDLE: begin
        // Clear wins when both requests arrive together.
        if (clear_start)     state_nxt = CLEAR;
        else if (draw_start) state_nxt = (draw_n == 4'd0) ? DONE : FETCH;
      end
      FETCH: begin
        mem_re    = 1'b1;
        mem_addr  = i_q + MEM_ADDR_W'(row);
        state_nxt = LATCH;
      end
      LATCH: begin
        col_clr   = 1'b1;
        state_nxt = PIX_RD;
      end
      PIX_RD: begin
        state_nxt = PIX_WR;
      end
      PIX_WR: begin
        // Only set sprite bits touch the screen; the write is the XOR result.
        fb_we   = sprite_bit;
        fb_wbit = ~fb_rbit;
        if (col != 3'd7) begin
          col_step  = 1'b1;
          state_nxt = PIX_RD;
        end else if (last_row) begin
          state_nxt = DONE;
        end else begin
          row_step  = 1'b1;
          state_nxt = FETCH;
        end
      end
      CLEAR: begin
        fb_we = 1'b1;
        if (clr_last) state_nxt = DONE;
        else          clr_step  = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_draw_controller.sv
// Scoreboard bench: expected latency/collision pushed per command, popped at done.
module tb_chip8_draw_controller;
  import chip8_draw_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        draw_start = 1'b0;
  logic        clear_start = 1'b0;
  logic [7:0]  draw_x = '0;
  logic [7:0]  draw_y = '0;
  logic [3:0]  draw_n = '0;
  logic [11:0] draw_i = '0;
  logic        busy, done, collision, mem_re, fb_wbit, fb_we, fb_rbit;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [5:0]  fb_x;
  logic [4:0]  fb_y;

  logic [7:0] mem [0:4095];
  bit         fb_mem [0:2047];
  bit         ref_fb [0:2047];
  int         rd_cnt, wr_cnt, col6_cnt, done_cnt, overlap_cnt;
  int         passed = 0;
  int         total = 0;

  typedef struct {
    int lat;
    bit coll;
  } exp_t;
  exp_t sb[$];

  chip8_draw_controller #(.MEM_ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .draw_start(draw_start), .clear_start(clear_start),
    .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n), .draw_i(draw_i),
    .busy(busy), .done(done), .collision(collision),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .fb_x(fb_x), .fb_y(fb_y), .fb_rbit(fb_rbit), .fb_wbit(fb_wbit), .fb_we(fb_we)
  );

  always #5 clk = ~clk;

  assign fb_rbit = fb_mem[{fb_y, fb_x}];

  // Memory and framebuffer models plus activity counters.
  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt++;
    end
    if (fb_we) begin
      fb_mem[{fb_y, fb_x}] <= fb_wbit;
      wr_cnt++;
      if (fb_x == 6'd6) col6_cnt++;
    end
    if (done) done_cnt++;
    if (done && fb_we) overlap_cnt++;
  end

  function automatic bit model_draw(input int x, input int y, input int n, input int i);
    bit c_any = 1'b0;
    logic [7:0] b;
    int idx;
    for (int r = 0; r < n; r++) begin
      b = mem[(i + r) % 4096];
      for (int c = 0; c < 8; c++) begin
        if (b[7-c]) begin
          idx = (((y % 32) + r) % 32) * 64 + ((x % 64) + c) % 64;
          if (ref_fb[idx]) c_any = 1'b1;
          ref_fb[idx] = !ref_fb[idx];
        end
      end
    end
    return c_any;
  endfunction

  function automatic int fb_diff();
    int d = 0;
    for (int k = 0; k < 2048; k++) if (fb_mem[k] != ref_fb[k]) d++;
    return d;
  endfunction

  function automatic int fb_set();
    int s = 0;
    for (int k = 0; k < 2048; k++) if (fb_mem[k]) s++;
    return s;
  endfunction

  // Push the expectation, issue the command, wait (bounded) for done.
  task automatic do_cmd(input bit clr, input bit drw, input int x, input int y,
                        input int n, input int i, input int poke_at,
                        output int lat, output bit coll);
    exp_t e;
    if (clr) begin
      e.lat = 2049; e.coll = 1'b0;
      for (int k = 0; k < 2048; k++) ref_fb[k] = 1'b0;
    end else if (n == 0) begin
      e.lat = 1; e.coll = 1'b0;
    end else begin
      e.coll = model_draw(x, y, n, i);
      e.lat  = 18 * n + 1;
    end
    sb.push_back(e);
    @(negedge clk);
    clear_start = clr;
    draw_start  = drw;
    draw_x = 8'(x); draw_y = 8'(y); draw_n = 4'(n); draw_i = 12'(i);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      clear_start = 1'b0;
      draw_start  = (lat == poke_at);
    end while (!done && lat <= 5000);
    draw_start = 1'b0;
    if (!done) $display("FAIL cmd_timeout: no done after %0d cycles", lat);
    coll = collision;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, collision, mem_re, fb_we, fb_wbit} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, collision, mem_re, fb_we, fb_wbit});
    else passed++;
    total++;
    if ({mem_addr, fb_x, fb_y} !== 23'd0)
      $display("FAIL reset_addr: got %h expected 0", {mem_addr, fb_x, fb_y});
    else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_font_draw(input string tag, input int exp_set);
    int lat; bit coll; exp_t e; int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_cmd(1'b0, 1'b1, 0, 0, 5, 'h050, -1, lat, coll);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat) $display("FAIL %s_latency: got %0d expected %0d", tag, lat, e.lat);
    else passed++;
    total++;
    if (coll !== e.coll) $display("FAIL %s_collision: got %0d expected %0d", tag, coll, e.coll);
    else passed++;
    total++;
    if (fb_diff() !== 0) $display("FAIL %s_pixels: got %0d differing pixels expected 0", tag, fb_diff());
    else passed++;
    total++;
    if (fb_set() !== exp_set) $display("FAIL %s_setcount: got %0d expected %0d", tag, fb_set(), exp_set);
    else passed++;
    total++;
    if ((rd_cnt - rd0) !== 5 || (wr_cnt - wr0) !== 14)
      $display("FAIL %s_accesses: got rd %0d wr %0d expected rd 5 wr 14", tag, rd_cnt - rd0, wr_cnt - wr0);
    else passed++;
  endtask

  task automatic test_zero_n();
    int lat; bit coll; exp_t e; int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_cmd(1'b0, 1'b1, 3, 3, 0, 'h050, -1, lat, coll);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat) $display("FAIL zero_n_latency: got %0d expected %0d", lat, e.lat);
    else passed++;
    total++;
    if (coll !== e.coll) $display("FAIL zero_n_collision: got %0d expected %0d", coll, e.coll);
    else passed++;
    total++;
    if ((rd_cnt - rd0) !== 0 || (wr_cnt - wr0) !== 0)
      $display("FAIL zero_n_accesses: got rd %0d wr %0d expected 0 0", rd_cnt - rd0, wr_cnt - wr0);
    else passed++;
  endtask

  task automatic test_wrap();
    int lat; bit coll; exp_t e; int c60;
    c60 = col6_cnt;
    do_cmd(1'b0, 1'b1, 62, 31, 2, 'h100, -1, lat, coll);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat || coll !== e.coll)
      $display("FAIL wrap_result: got lat %0d coll %0d expected lat %0d coll %0d", lat, coll, e.lat, e.coll);
    else passed++;
    total++;
    if (fb_diff() !== 0) $display("FAIL wrap_pixels: got %0d differing pixels expected 0", fb_diff());
    else passed++;
    total++;
    if ((col6_cnt - c60) !== 0) $display("FAIL wrap_col6: got %0d writes expected 0", col6_cnt - c60);
    else passed++;
    total++;
    if ({fb_mem[31*64+5], fb_mem[5], fb_mem[62], fb_mem[63]} !== 4'b1110)
      $display("FAIL wrap_corners: got %b expected 1110",
               {fb_mem[31*64+5], fb_mem[5], fb_mem[62], fb_mem[63]});
    else passed++;
  endtask

  task automatic test_clear_priority();
    int lat; bit coll; exp_t e; int rd0, wr0, d0;
    do_cmd(1'b0, 1'b1, 70, 40, 1, 'h050, -1, lat, coll);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat || coll !== e.coll)
      $display("FAIL wrapxy_result: got lat %0d coll %0d expected lat %0d coll %0d", lat, coll, e.lat, e.coll);
    else passed++;
    do_cmd(1'b0, 1'b1, 6, 8, 1, 'h051, -1, lat, coll);
    e = sb.pop_front();
    total++;
    if (coll !== e.coll) $display("FAIL overlap_collision: got %0d expected %0d", coll, e.coll);
    else passed++;
    total++;
    if (fb_diff() !== 0) $display("FAIL overlap_pixels: got %0d differing pixels expected 0", fb_diff());
    else passed++;
    rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_cnt;
    do_cmd(1'b1, 1'b1, 0, 0, 5, 'h050, 100, lat, coll);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat) $display("FAIL clear_latency: got %0d expected %0d", lat, e.lat);
    else passed++;
    total++;
    if (coll !== e.coll) $display("FAIL clear_collision: got %0d expected %0d", coll, e.coll);
    else passed++;
    total++;
    if (fb_set() !== 0) $display("FAIL clear_pixels: got %0d set expected 0", fb_set());
    else passed++;
    total++;
    if ((wr_cnt - wr0) !== 2048 || (rd_cnt - rd0) !== 0)
      $display("FAIL clear_accesses: got wr %0d rd %0d expected wr 2048 rd 0", wr_cnt - wr0, rd_cnt - rd0);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || (done_cnt - d0) !== 1)
      $display("FAIL clear_no_queue: got busy %0d dones %0d expected 0 1", busy, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; bit coll; exp_t e; int d0;
    d0 = done_cnt;
    @(negedge clk);
    draw_start = 1'b1; draw_x = 8'd20; draw_y = 8'd12; draw_n = 4'd5; draw_i = 12'h050;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      draw_start = 1'b0;
    end
    total++;
    if (fb_we !== 1'b1) $display("FAIL midreset_pre_we: got %0d expected 1", fb_we);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (fb_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_async: got fb_we %0d busy %0d expected 0 0", fb_we, busy);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    total++;
    if ((done_cnt - d0) !== 0 || busy !== 1'b0)
      $display("FAIL midreset_no_done: got dones %0d busy %0d expected 0 0", done_cnt - d0, busy);
    else passed++;
    for (int k = 0; k < 2048; k++) ref_fb[k] = fb_mem[k];
    do_cmd(1'b0, 1'b1, 20, 12, 5, 'h050, -1, lat, coll);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat || coll !== e.coll)
      $display("FAIL post_reset_draw: got lat %0d coll %0d expected lat %0d coll %0d", lat, coll, e.lat, e.coll);
    else passed++;
    total++;
    if (fb_diff() !== 0) $display("FAIL post_reset_pixels: got %0d differing pixels expected 0", fb_diff());
    else passed++;
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    mem['h050] = 8'hF0; mem['h051] = 8'h90; mem['h052] = 8'h90;
    mem['h053] = 8'h90; mem['h054] = 8'hF0;
    mem['h100] = 8'hFF; mem['h101] = 8'h81;

    test_reset();
    test_font_draw("font", 14);
    test_font_draw("erase", 0);
    test_zero_n();
    test_wrap();
    test_clear_priority();
    test_reset_mid();

    total++;
    if (overlap_cnt !== 0) $display("FAIL done_with_we: got %0d cycles expected 0", overlap_cnt);
    else passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
